// File: rtl/sc_frogger_pkg.sv
// Shared types and constants for the lane scroll control slice.
package sc_frogger_pkg;

  // Controller FSM states
  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StRun,
    StPause
  } state_e;

  // Lane register shift-selection codes
  localparam logic [1:0] SHIFT_NONE  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  // Game levels; the value doubles as the lane register transition selector
  localparam logic [1:0] LVL_1 = 2'd0;
  localparam logic [1:0] LVL_2 = 2'd1;
  localparam logic [1:0] LVL_3 = 2'd2;
  localparam logic [1:0] LVL_4 = 2'd3;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Free-running prescaler with a selectable terminal value. Emits a one-cycle
// combinational tick in the cycle the counter sits at its terminal value.
module sc_tick_prescaler
  import sc_frogger_pkg::*;
#(
  parameter int unsigned CntWidth = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] term_i,
  output logic                tick_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // >= rather than == so a shortened terminal can never let the count run away
  assign tick_o = en_i && (cnt_q >= term_i);

  // Next count: clear wins, otherwise count up and restart at the terminal value
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (tick_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  // Counter register, synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_lane_scroll_ctrl.sv
// Lane scroll controller: sequences clear, pattern load and level-dependent
// periodic rotate commands for one lane background register.
module sc_lane_scroll_ctrl
  import sc_frogger_pkg::*;
#(
  parameter int unsigned          CNT_WIDTH = 24,
  parameter logic [CNT_WIDTH-1:0] PERIOD_L1 = 24'd12_500_000,
  parameter logic [CNT_WIDTH-1:0] PERIOD_L2 = 24'd8_000_000,
  parameter logic [CNT_WIDTH-1:0] PERIOD_L3 = 24'd5_000_000,
  parameter logic [CNT_WIDTH-1:0] PERIOD_L4 = 24'd2_500_000,
  parameter bit                   DIRECTION = 1'b1
) (
  input  logic       SC_LaneScrollCtrl_CLOCK_50,
  input  logic       SC_LaneScrollCtrl_RESET_InHigh,
  input  logic       SC_LaneScrollCtrl_start_InLow,
  input  logic       SC_LaneScrollCtrl_levelup_InLow,
  input  logic       SC_LaneScrollCtrl_pause_InHigh,
  input  logic       SC_LaneScrollCtrl_gameover_InHigh,
  output logic       SC_LaneScrollCtrl_clear_OutLow,
  output logic       SC_LaneScrollCtrl_load_OutLow,
  output logic [1:0] SC_LaneScrollCtrl_shiftselection_Out,
  output logic [1:0] SC_LaneScrollCtrl_level_Out,
  output logic       SC_LaneScrollCtrl_running_OutHigh
);

  localparam logic [1:0] DirCode = DIRECTION ? SHIFT_LEFT : SHIFT_RIGHT;

  logic clk;
  logic rst;
  assign clk = SC_LaneScrollCtrl_CLOCK_50;
  assign rst = SC_LaneScrollCtrl_RESET_InHigh;

  state_e     state_q, state_d;
  logic [1:0] level_q, level_d;
  logic       clear_n_q, clear_n_d;
  logic       load_n_q, load_n_d;
  logic [1:0] shift_q, shift_d;
  logic       running_q, running_d;

  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 tick;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] term;

  // Scroll period for the current level
  always_comb begin
    unique case (level_q)
      LVL_1:   period = PERIOD_L1;
      LVL_2:   period = PERIOD_L2;
      LVL_3:   period = PERIOD_L3;
      LVL_4:   period = PERIOD_L4;
      default: period = PERIOD_L1;
    endcase
    term = period - CNT_WIDTH'(1);
  end

  sc_tick_prescaler #(
    .CntWidth (CNT_WIDTH)
  ) u_prescaler (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (term),
    .tick_o (tick)
  );

  // Next state and next registered outputs; priority gameover > start > levelup > pause > tick
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    clear_n_d = 1'b1;
    load_n_d  = 1'b1;
    shift_d   = SHIFT_NONE;
    running_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    if (state_q != StIdle && SC_LaneScrollCtrl_gameover_InHigh) begin
      state_d = StIdle;
      cnt_clr = 1'b1;
    end else if (!SC_LaneScrollCtrl_start_InLow) begin
      state_d   = StClear;
      level_d   = LVL_1;
      clear_n_d = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_clr = 1'b1;
        end
        StClear: begin
          state_d  = StLoad;
          load_n_d = 1'b0;
          cnt_clr  = 1'b1;
        end
        StLoad: begin
          state_d   = StRun;
          running_d = 1'b1;
          cnt_clr   = 1'b1;
        end
        StRun: begin
          if (!SC_LaneScrollCtrl_levelup_InLow && level_q != LVL_4) begin
            // Level change reloads the lane pattern for the new level
            state_d  = StLoad;
            level_d  = level_q + 2'd1;
            load_n_d = 1'b0;
            cnt_clr  = 1'b1;
          end else if (SC_LaneScrollCtrl_pause_InHigh) begin
            state_d = StPause;
          end else begin
            running_d = 1'b1;
            cnt_en    = 1'b1;
            if (tick) begin
              shift_d = DirCode;
            end
          end
        end
        StPause: begin
          if (!SC_LaneScrollCtrl_pause_InHigh) begin
            state_d   = StRun;
            running_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      level_q   <= LVL_1;
      clear_n_q <= 1'b1;
      load_n_q  <= 1'b1;
      shift_q   <= SHIFT_NONE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      clear_n_q <= clear_n_d;
      load_n_q  <= load_n_d;
      shift_q   <= shift_d;
      running_q <= running_d;
    end
  end

  assign SC_LaneScrollCtrl_clear_OutLow        = clear_n_q;
  assign SC_LaneScrollCtrl_load_OutLow         = load_n_q;
  assign SC_LaneScrollCtrl_shiftselection_Out  = shift_q;
  assign SC_LaneScrollCtrl_level_Out           = level_q;
  assign SC_LaneScrollCtrl_running_OutHigh     = running_q;

endmodule

// File: tb/tb_sc_lane_scroll_ctrl.sv
// Bench for sc_lane_scroll_ctrl: directed scenarios plus random events,
// all checked against a behavioural game-flow model.
module tb_sc_lane_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       levelup_n = 1'b1;
  logic       pause = 1'b0;
  logic       gameover = 1'b0;
  logic       dut_clear_n;
  logic       dut_load_n;
  logic [1:0] dut_shift;
  logic [1:0] dut_level;
  logic       dut_running;

  always #5 clk = ~clk;

  sc_lane_scroll_ctrl #(
    .CNT_WIDTH (24),
    .PERIOD_L1 (24'd4),
    .PERIOD_L2 (24'd3),
    .PERIOD_L3 (24'd2),
    .PERIOD_L4 (24'd2),
    .DIRECTION (1'b1)
  ) dut (
    .SC_LaneScrollCtrl_CLOCK_50           (clk),
    .SC_LaneScrollCtrl_RESET_InHigh       (rst),
    .SC_LaneScrollCtrl_start_InLow        (start_n),
    .SC_LaneScrollCtrl_levelup_InLow      (levelup_n),
    .SC_LaneScrollCtrl_pause_InHigh       (pause),
    .SC_LaneScrollCtrl_gameover_InHigh    (gameover),
    .SC_LaneScrollCtrl_clear_OutLow       (dut_clear_n),
    .SC_LaneScrollCtrl_load_OutLow        (dut_load_n),
    .SC_LaneScrollCtrl_shiftselection_Out (dut_shift),
    .SC_LaneScrollCtrl_level_Out          (dut_level),
    .SC_LaneScrollCtrl_running_OutHigh    (dut_running)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: game phase, level and cycles spent in the current scroll period
  localparam int ModeIdle  = 0;
  localparam int ModeClear = 1;
  localparam int ModeLoad  = 2;
  localparam int ModeRun   = 3;
  localparam int ModePause = 4;

  int m_mode = ModeIdle;
  int m_lvl = 0;
  int m_elapsed = 0;
  bit m_pulse = 0;
  int period_tbl[4] = '{4, 3, 2, 2};

  task automatic model_step(input bit r, input bit st_n, input bit lu_n, input bit ps,
                            input bit go);
    m_pulse = 0;
    if (r) begin
      m_mode = ModeIdle;
      m_lvl = 0;
      m_elapsed = 0;
    end else if (m_mode != ModeIdle && go) begin
      m_mode = ModeIdle;
      m_elapsed = 0;
    end else if (!st_n) begin
      m_mode = ModeClear;
      m_lvl = 0;
      m_elapsed = 0;
    end else begin
      case (m_mode)
        ModeClear: m_mode = ModeLoad;
        ModeLoad: begin
          m_mode = ModeRun;
          m_elapsed = 0;
        end
        ModeRun: begin
          if (!lu_n && m_lvl < 3) begin
            m_lvl++;
            m_elapsed = 0;
            m_mode = ModeLoad;
          end else if (ps) begin
            m_mode = ModePause;
          end else begin
            m_elapsed++;
            if (m_elapsed == period_tbl[m_lvl]) begin
              m_elapsed = 0;
              m_pulse = 1;
            end
          end
        end
        ModePause: if (!ps) m_mode = ModeRun;
        default: ;
      endcase
    end
  endtask

  int edge_cnt = 0;
  int pulse_q[$];

  // One clock: drive on the falling edge, update the model at the rising edge, compare 1ns later
  task automatic step(input bit r, input bit st_n, input bit lu_n, input bit ps, input bit go);
    @(negedge clk);
    rst = r;
    start_n = st_n;
    levelup_n = lu_n;
    pause = ps;
    gameover = go;
    @(posedge clk);
    model_step(r, st_n, lu_n, ps, go);
    edge_cnt++;
    #1;
    check_eq("clear_n", 32'(dut_clear_n), 32'(m_mode != ModeClear));
    check_eq("load_n", 32'(dut_load_n), 32'(m_mode != ModeLoad));
    check_eq("running", 32'(dut_running), 32'(m_mode == ModeRun));
    check_eq("level", 32'(dut_level), 32'(m_lvl));
    check_eq("shift", 32'(dut_shift), m_pulse ? 32'h1 : 32'h0);
    check_eq("clr_ld_excl", 32'(!dut_clear_n && !dut_load_n), 32'h0);
    if (dut_shift != 2'b00) pulse_q.push_back(edge_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic int pulse_at(input int idx);
    if (idx < pulse_q.size()) return pulse_q[idx];
    return -1000;
  endfunction

  int k;
  bit r_ps;

  initial begin
    // Reset
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rst_clear_n", 32'(dut_clear_n), 32'h1);
    check_eq("rst_shift", 32'(dut_shift), 32'h0);

    // Start and first pulses at level 0
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    k = edge_cnt;
    pulse_q.delete();
    idle(14);
    check_eq("l0_pulse_count", 32'(pulse_q.size()), 32'd3);
    check_eq("l0_first_pulse", 32'(pulse_at(0) - k), 32'd6);
    check_eq("l0_spacing", 32'(pulse_at(1) - pulse_at(0)), 32'd4);

    // Level up to 1: load pulse with new level, then period 3
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    k = edge_cnt;
    check_eq("lu1_level", 32'(dut_level), 32'd1);
    check_eq("lu1_load_n", 32'(dut_load_n), 32'd0);
    pulse_q.delete();
    idle(10);
    check_eq("l1_first_pulse", 32'(pulse_at(0) - k), 32'd4);
    check_eq("l1_spacing", 32'(pulse_at(1) - pulse_at(0)), 32'd3);

    // Up to level 3, then a saturating levelup
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
    end
    check_eq("lvl3", 32'(dut_level), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("sat_level", 32'(dut_level), 32'd3);
    check_eq("sat_load_n", 32'(dut_load_n), 32'd1);
    pulse_q.delete();
    idle(8);
    check_eq("l3_spacing", 32'(pulse_at(1) - pulse_at(0)), 32'd2);

    // Pause mid-count (counter at 2) at level 0
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    pulse_q.delete();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("pause_no_pulse", 32'(pulse_q.size()), 32'd0);
    check_eq("pause_running", 32'(dut_running), 32'd0);
    idle(1);
    k = edge_cnt;
    idle(4);
    check_eq("resume_pulse", 32'(pulse_at(0) - k), 32'd2);

    // Gameover coinciding with a terminal count
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    pulse_q.delete();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("go_shift", 32'(dut_shift), 32'd0);
    check_eq("go_running", 32'(dut_running), 32'd0);
    idle(6);
    check_eq("go_idle_pulses", 32'(pulse_q.size()), 32'd0);

    // Reset during LOAD
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check_eq("pre_rst_load_n", 32'(dut_load_n), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rst_load_load_n", 32'(dut_load_n), 32'd1);
    idle(4);
    check_eq("rst_load_running", 32'(dut_running), 32'd0);

    // Random events
    r_ps = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) r_ps = ~r_ps;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 39) != 0,
           $urandom_range(0, 11) != 0, r_ps, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
